// File: rtl/param_load_ctrl_if.sv
// Byte-stream and status bundle between the host front-end (master) and param_load_ctrl (slave).
// byte_count width follows CNT_W so it can track NUM_PARAMS bytes per load.
interface param_load_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             load_start;
  logic             abort;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sr_sel;
  logic [7:0]       sr_data;
  logic             busy;
  logic             params_valid;
  logic             load_done;
  logic             err;
  logic [CNT_W-1:0] byte_count;

  modport master (
    output load_start, abort, in_data, in_valid,
    input  in_ready, sr_sel, sr_data, busy, params_valid, load_done, err, byte_count
  );

  modport slave (
    input  load_start, abort, in_data, in_valid,
    output in_ready, sr_sel, sr_data, busy, params_valid, load_done, err, byte_count
  );
endinterface

// File: rtl/param_load_ctrl.sv
// Sequences NUM_PARAMS byte shifts into the parameter register, one per accepted beat, zero-latency shift;
// in_ready drops when idle or on abort. Optional trailing checksum byte under PARAM_CHECKSUM_EN.
module param_load_ctrl #(
  parameter int NUM_PARAMS = 20,
  parameter int CNT_W      = 5
) (
  input  logic               clk,
  input  logic               reset,
  param_load_ctrl_if.slave   pif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
`ifdef PARAM_CHECKSUM_EN
  localparam logic [1:0] ST_CHK  = 2'd2;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PARAMS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pv_q, pv_d;
  logic             done_q, done_d;
  logic             in_phase;
  logic             in_ready;
  logic             accept;
  logic             shift;

`ifdef PARAM_CHECKSUM_EN
  logic             err_q, err_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       csum_sum;

  assign in_phase = (state_q == ST_LOAD) || (state_q == ST_CHK);
  assign csum_sum = csum_q + pif.in_data;
`else
  assign in_phase = (state_q == ST_LOAD);
`endif

  assign in_ready = in_phase & ~pif.abort;
  assign accept   = pif.in_valid & in_ready;
  // Only parameter bytes shift; the checksum byte is consumed without touching the register.
  assign shift    = accept & (state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pv_d    = pv_q;
    done_d  = 1'b0;
`ifdef PARAM_CHECKSUM_EN
    err_d   = err_q;
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pif.load_start) begin
          state_d = ST_LOAD;
          count_d = '0;
          pv_d    = 1'b0;
`ifdef PARAM_CHECKSUM_EN
          err_d   = 1'b0;
          csum_d  = 8'h00;
`endif
        end
      end
      ST_LOAD: begin
        if (pif.abort) begin
          state_d = ST_IDLE;
          pv_d    = 1'b0;
        end else if (accept) begin
          count_d = count_q + CNT_W'(1);
`ifdef PARAM_CHECKSUM_EN
          csum_d  = csum_sum;
          if (count_q == LAST_IDX) begin
            state_d = ST_CHK;
          end
`else
          if (count_q == LAST_IDX) begin
            state_d = ST_IDLE;
            pv_d    = 1'b1;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef PARAM_CHECKSUM_EN
      ST_CHK: begin
        if (pif.abort) begin
          state_d = ST_IDLE;
          pv_d    = 1'b0;
        end else if (accept) begin
          state_d = ST_IDLE;
          if (csum_sum == 8'h00) begin
            pv_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
    end
  end

`ifdef PARAM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q  <= 1'b0;
      csum_q <= 8'h00;
    end else begin
      err_q  <= err_d;
      csum_q <= csum_d;
    end
  end

  assign pif.err = err_q;
`else
  assign pif.err = 1'b0;
`endif

  assign pif.in_ready     = in_ready;
  assign pif.sr_sel       = shift ? 2'b01 : 2'b00;
  assign pif.sr_data      = shift ? pif.in_data : 8'h00;
  assign pif.busy         = (state_q != ST_IDLE);
  assign pif.params_valid = pv_q;
  assign pif.load_done    = done_q;
  assign pif.byte_count   = count_q;

endmodule

// File: tb/tb_param_load_ctrl.sv
// Directed bench for param_load_ctrl with a byte-wide model of the 20-entry parameter shift register.
module tb_param_load_ctrl;
  localparam int NP = 20;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;

  param_load_ctrl_if #(.CNT_W(CW)) pif();

  param_load_ctrl #(.NUM_PARAMS(NP), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int shifts;
  int dones;
  int bad_sel;
  logic [7:0] regm [NP];

  // Sample the shift request just before the edge, advance, then look at registered outputs.
  task automatic tick();
    if (pif.sr_sel == 2'b01) begin
      for (int i = 0; i < NP - 1; i++) regm[i] = regm[i+1];
      regm[NP-1] = pif.sr_data;
      shifts++;
    end
    @(posedge clk);
    #1;
    if (pif.load_done === 1'b1) dones++;
  endtask

  task automatic idle_inputs();
    pif.load_start = 1'b0;
    pif.abort      = 1'b0;
    pif.in_data    = 8'h00;
    pif.in_valid   = 1'b0;
  endtask

  task automatic start_load();
    pif.load_start = 1'b1;
    #1;
    tick();
    pif.load_start = 1'b0;
    #1;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gap);
    logic [7:0] bv;
    for (int b = lo; b <= hi; b++) begin
      bv = 8'(b);
      if (gap) begin
        pif.in_valid = 1'b0;
        #1;
        if (pif.sr_sel !== 2'b00) bad_sel++;
        tick();
      end
      pif.in_valid = 1'b1;
      pif.in_data  = bv;
      #1;
      if (pif.sr_sel !== 2'b01 || pif.sr_data !== bv) bad_sel++;
      tick();
    end
    pif.in_valid = 1'b0;
    pif.in_data  = 8'h00;
    #1;
  endtask

`ifdef PARAM_CHECKSUM_EN
  task automatic send_checksum(input logic [7:0] cb);
    pif.in_valid = 1'b1;
    pif.in_data  = cb;
    #1;
    if (pif.sr_sel !== 2'b00 || pif.in_ready !== 1'b1) bad_sel++;
    tick();
    pif.in_valid = 1'b0;
    pif.in_data  = 8'h00;
    #1;
  endtask
`endif

  task automatic finish_good();
`ifdef PARAM_CHECKSUM_EN
    send_checksum(8'h2E);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) tick();
    vectors++; if (pif.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", pif.in_ready); end
    vectors++; if (pif.sr_sel !== 2'b00) begin miscompares++; $display("FAIL reset_sr_sel: got %b want 00", pif.sr_sel); end
    vectors++; if (pif.sr_data !== 8'h00) begin miscompares++; $display("FAIL reset_sr_data: got %h want 00", pif.sr_data); end
    vectors++; if (pif.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", pif.busy); end
    vectors++; if (pif.params_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pv: got %b want 0", pif.params_valid); end
    vectors++; if (pif.load_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", pif.load_done); end
    vectors++; if (pif.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", pif.err); end
    vectors++; if (pif.byte_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", pif.byte_count); end
    pif.in_valid = 1'b1;
    pif.in_data  = 8'hAA;
    #1;
    vectors++; if (pif.in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_in_ready: got %b want 0", pif.in_ready); end
    vectors++; if (pif.sr_sel !== 2'b00) begin miscompares++; $display("FAIL idle_sr_sel: got %b want 00", pif.sr_sel); end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_full_load();
    start_load();
    vectors++; if (pif.busy !== 1'b1) begin miscompares++; $display("FAIL full_start_busy: got %b want 1", pif.busy); end
    vectors++; if (pif.in_ready !== 1'b1) begin miscompares++; $display("FAIL full_start_ready: got %b want 1", pif.in_ready); end
    vectors++; if (pif.byte_count !== 5'd0) begin miscompares++; $display("FAIL full_start_count: got %0d want 0", pif.byte_count); end
    shifts = 0; dones = 0; bad_sel = 0;
    send_range(1, NP, 1'b0);
`ifdef PARAM_CHECKSUM_EN
    vectors++; if (pif.busy !== 1'b1) begin miscompares++; $display("FAIL chk_busy: got %b want 1", pif.busy); end
    vectors++; if (pif.params_valid !== 1'b0) begin miscompares++; $display("FAIL chk_pv: got %b want 0", pif.params_valid); end
    send_checksum(8'h2E);
`endif
    vectors++; if (pif.params_valid !== 1'b1) begin miscompares++; $display("FAIL full_pv: got %b want 1", pif.params_valid); end
    vectors++; if (pif.busy !== 1'b0) begin miscompares++; $display("FAIL full_busy: got %b want 0", pif.busy); end
    vectors++; if (pif.err !== 1'b0) begin miscompares++; $display("FAIL full_err: got %b want 0", pif.err); end
    vectors++; if (pif.byte_count !== 5'd20) begin miscompares++; $display("FAIL full_count: got %0d want 20", pif.byte_count); end
    vectors++; if (pif.load_done !== 1'b1) begin miscompares++; $display("FAIL full_done_hi: got %b want 1", pif.load_done); end
    tick();
    vectors++; if (pif.load_done !== 1'b0) begin miscompares++; $display("FAIL full_done_lo: got %b want 0", pif.load_done); end
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL full_done_pulses: got %0d want 1", dones); end
    vectors++; if (shifts !== NP) begin miscompares++; $display("FAIL full_shifts: got %0d want %0d", shifts, NP); end
    vectors++; if (bad_sel !== 0) begin miscompares++; $display("FAIL full_sel_data: got %0d bad beats want 0", bad_sel); end
    for (int i = 0; i < NP; i++) begin
      vectors++;
      if (regm[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL full_reg[%0d]: got %h want %h", i, regm[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_gapped_load();
    for (int i = 0; i < NP; i++) regm[i] = 8'hFF;
    start_load();
    shifts = 0; dones = 0; bad_sel = 0;
    send_range(1, NP, 1'b1);
    finish_good();
    vectors++; if (pif.params_valid !== 1'b1) begin miscompares++; $display("FAIL gap_pv: got %b want 1", pif.params_valid); end
    tick();
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL gap_done_pulses: got %0d want 1", dones); end
    vectors++; if (shifts !== NP) begin miscompares++; $display("FAIL gap_shifts: got %0d want %0d", shifts, NP); end
    vectors++; if (bad_sel !== 0) begin miscompares++; $display("FAIL gap_sel_data: got %0d bad beats want 0", bad_sel); end
    for (int i = 0; i < NP; i++) begin
      vectors++;
      if (regm[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL gap_reg[%0d]: got %h want %h", i, regm[i], 8'(i + 1)); end
    end
  endtask

`ifdef PARAM_CHECKSUM_EN
  task automatic test_checksum_bad();
    start_load();
    dones = 0;
    send_range(1, NP, 1'b0);
    send_checksum(8'h00);
    vectors++; if (pif.err !== 1'b1) begin miscompares++; $display("FAIL csum_err: got %b want 1", pif.err); end
    vectors++; if (pif.params_valid !== 1'b0) begin miscompares++; $display("FAIL csum_pv: got %b want 0", pif.params_valid); end
    vectors++; if (pif.busy !== 1'b0) begin miscompares++; $display("FAIL csum_busy: got %b want 0", pif.busy); end
    tick();
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL csum_done_pulses: got %0d want 0", dones); end
  endtask
`endif

  task automatic test_abort();
    start_load();
    vectors++; if (pif.params_valid !== 1'b0) begin miscompares++; $display("FAIL abort_start_pv: got %b want 0", pif.params_valid); end
    shifts = 0; dones = 0;
    send_range(1, 6, 1'b0);
    pif.abort    = 1'b1;
    pif.in_valid = 1'b1;
    pif.in_data  = 8'd7;
    #1;
    vectors++; if (pif.in_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %b want 0", pif.in_ready); end
    vectors++; if (pif.sr_sel !== 2'b00) begin miscompares++; $display("FAIL abort_sr_sel: got %b want 00", pif.sr_sel); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (pif.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", pif.busy); end
    vectors++; if (pif.params_valid !== 1'b0) begin miscompares++; $display("FAIL abort_pv: got %b want 0", pif.params_valid); end
    vectors++; if (pif.err !== 1'b0) begin miscompares++; $display("FAIL abort_err: got %b want 0", pif.err); end
    vectors++; if (pif.byte_count !== 5'd6) begin miscompares++; $display("FAIL abort_count: got %0d want 6", pif.byte_count); end
    vectors++; if (shifts !== 6) begin miscompares++; $display("FAIL abort_shifts: got %0d want 6", shifts); end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL abort_done_pulses: got %0d want 0", dones); end
    start_load();
    vectors++; if (pif.byte_count !== 5'd0) begin miscompares++; $display("FAIL restart_count: got %0d want 0", pif.byte_count); end
    vectors++; if (pif.busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b want 1", pif.busy); end
    send_range(1, NP, 1'b0);
    finish_good();
    vectors++; if (pif.params_valid !== 1'b1) begin miscompares++; $display("FAIL restart_pv: got %b want 1", pif.params_valid); end
    vectors++; if (pif.byte_count !== 5'd20) begin miscompares++; $display("FAIL restart_count_end: got %0d want 20", pif.byte_count); end
    tick();
  endtask

  task automatic test_async_reset();
    start_load();
    send_range(1, 9, 1'b0);
    pif.in_valid = 1'b1;
    pif.in_data  = 8'd10;
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (pif.busy !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b want 0", pif.busy); end
    vectors++; if (pif.in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_ready: got %b want 0", pif.in_ready); end
    vectors++; if (pif.sr_sel !== 2'b00) begin miscompares++; $display("FAIL arst_sr_sel: got %b want 00", pif.sr_sel); end
    vectors++; if (pif.sr_data !== 8'h00) begin miscompares++; $display("FAIL arst_sr_data: got %h want 00", pif.sr_data); end
    vectors++; if (pif.byte_count !== 5'd0) begin miscompares++; $display("FAIL arst_count: got %0d want 0", pif.byte_count); end
    vectors++; if (pif.params_valid !== 1'b0) begin miscompares++; $display("FAIL arst_pv: got %b want 0", pif.params_valid); end
    reset = 1'b0;
    idle_inputs();
    #1;
    tick();
    vectors++; if (pif.busy !== 1'b0) begin miscompares++; $display("FAIL arst_after_busy: got %b want 0", pif.busy); end
  endtask

  task automatic test_start_ignored();
    start_load();
    shifts = 0;
    send_range(1, 5, 1'b0);
    pif.load_start = 1'b1;
    pif.in_valid   = 1'b1;
    pif.in_data    = 8'd6;
    #1;
    tick();
    idle_inputs();
    #1;
    vectors++; if (pif.byte_count !== 5'd6) begin miscompares++; $display("FAIL ign_count: got %0d want 6", pif.byte_count); end
    vectors++; if (pif.busy !== 1'b1) begin miscompares++; $display("FAIL ign_busy: got %b want 1", pif.busy); end
    send_range(7, NP, 1'b0);
    finish_good();
    vectors++; if (pif.params_valid !== 1'b1) begin miscompares++; $display("FAIL ign_pv: got %b want 1", pif.params_valid); end
    vectors++; if (pif.byte_count !== 5'd20) begin miscompares++; $display("FAIL ign_count_end: got %0d want 20", pif.byte_count); end
    vectors++; if (shifts !== NP) begin miscompares++; $display("FAIL ign_shifts: got %0d want %0d", shifts, NP); end
    vectors++; if (regm[0] !== 8'd1 || regm[NP-1] !== 8'd20) begin miscompares++; $display("FAIL ign_reg_ends: got %h/%h want 01/14", regm[0], regm[NP-1]); end
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    shifts = 0; dones = 0; bad_sel = 0;
    for (int i = 0; i < NP; i++) regm[i] = 8'h00;
    test_reset();
    test_full_load();
    test_gapped_load();
`ifdef PARAM_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_abort();
    test_async_reset();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
